// File: rtl/mult8_seq_ctrl.sv
// mult8_seq_ctrl
//   Sequential 8x8 unsigned multiplier controller. The 8-bit operands are split
//   into nibbles and fed, one partial product per cycle, to an external
//   combinational 4x4 array multiplier. The shifted partial products are summed
//   into an accumulator, and the result is presented with a valid/ready handshake.
//
//   Parameter
//     SKIP_ZERO  1: skip the partial-product steps whose b nibble is zero.
//   Optional build macro
//     MULT8_MAC_EN  adds in_c (addend loaded into the accumulator on accept)
//                   and out_ovf (bit 16 of a*b+c). The accumulator becomes 17 bits.
//
//   Ports
//     clk, rst            clock; synchronous active-high reset
//     in_valid/in_ready   operand handshake; in_a, in_b unsigned operands
//     out_valid/out_ready result handshake; out_p 16-bit product
//     mul_a, mul_b        nibbles driven to the external multiplier
//     mul_q               external multiplier result (mul_a*mul_b, same cycle)
//     in_c, out_ovf       only with MULT8_MAC_EN

module mult8_seq_ctrl #(
    parameter int SKIP_ZERO = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
`ifdef MULT8_MAC_EN
    input  logic [15:0] in_c,
    output logic        out_ovf,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_p,
    output logic [3:0]  mul_a,
    output logic [3:0]  mul_b,
    input  logic [7:0]  mul_q
);

`ifdef MULT8_MAC_EN
    localparam int ACC_W = 17;
`else
    localparam int ACC_W = 16;
`endif

    typedef enum logic [2:0] {IDLE, PP0, PP1, PP2, PP3, DONE} state_t;

    state_t             state_q, state_d;
    logic [7:0]         a_r, b_r;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_init;
    logic [ACC_W-1:0]   addend;
    logic [7:0]         b_sel;
    logic               lo_skip, hi_skip;
    logic               accept;
    logic               pp_active;
    logic [3:0]         shift;

    assign accept = in_valid & in_ready;

    // In IDLE the operand registers are not loaded yet, so the skip decision
    // for the first step must look at the incoming operand directly.
    assign b_sel   = (state_q == IDLE) ? in_b : b_r;
    assign lo_skip = (SKIP_ZERO != 0) && (b_sel[3:0] == 4'd0);
    assign hi_skip = (SKIP_ZERO != 0) && (b_sel[7:4] == 4'd0);

`ifdef MULT8_MAC_EN
    assign acc_init = {1'b0, in_c};
`else
    assign acc_init = '0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) begin
                if (!lo_skip)      state_d = PP0;
                else if (!hi_skip) state_d = PP2;
                else               state_d = DONE;
            end
            PP0:  state_d = PP1;
            PP1:  state_d = hi_skip ? DONE : PP2;
            PP2:  state_d = PP3;
            PP3:  state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath-control logic
    always_comb begin
        mul_a     = 4'd0;
        mul_b     = 4'd0;
        shift     = 4'd0;
        pp_active = 1'b0;
        in_ready  = (state_q == IDLE) && !rst;
        out_valid = (state_q == DONE);
        unique case (state_q)
            PP0: begin mul_a = a_r[3:0]; mul_b = b_r[3:0]; shift = 4'd0; pp_active = 1'b1; end
            PP1: begin mul_a = a_r[7:4]; mul_b = b_r[3:0]; shift = 4'd4; pp_active = 1'b1; end
            PP2: begin mul_a = a_r[3:0]; mul_b = b_r[7:4]; shift = 4'd4; pp_active = 1'b1; end
            PP3: begin mul_a = a_r[7:4]; mul_b = b_r[7:4]; shift = 4'd8; pp_active = 1'b1; end
            default: ;
        endcase
    end

    assign addend = ACC_W'(mul_q) << shift;

    // Operand registers and accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r <= 8'd0;
            b_r <= 8'd0;
            acc <= '0;
        end else if (accept) begin
            a_r <= in_a;
            b_r <= in_b;
            acc <= acc_init;
        end else if (pp_active) begin
            acc <= acc + addend;
        end
    end

    // The accumulator is frozen in DONE, so out_p is stable under backpressure.
    assign out_p = acc[15:0];
`ifdef MULT8_MAC_EN
    assign out_ovf = acc[16];
`endif

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Directed bench for mult8_seq_ctrl. Two instances: u1 (SKIP_ZERO=1) and
// u0 (SKIP_ZERO=0), each with its own behavioural 4x4 multiplier.
module tb_mult8_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid1, in_valid0, out_ready;
    logic [7:0]  in_a, in_b;
    logic [15:0] in_c;
    logic        in_ready1, in_ready0, out_valid1, out_valid0;
    logic [15:0] out_p1, out_p0;
    logic [3:0]  mul_a1, mul_b1, mul_a0, mul_b0;
    logic [7:0]  mul_q1, mul_q0;
    logic        out_ovf1;

    int nvec = 0;
    int nerr = 0;
    logic [7:0] pp_q[$];

    always #5 clk = ~clk;

    assign mul_q1 = {4'd0, mul_a1} * {4'd0, mul_b1};
    assign mul_q0 = {4'd0, mul_a0} * {4'd0, mul_b0};

    mult8_seq_ctrl #(.SKIP_ZERO(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a), .in_b(in_b),
`ifdef MULT8_MAC_EN
        .in_c(in_c), .out_ovf(out_ovf1),
`endif
        .out_valid(out_valid1), .out_ready(out_ready), .out_p(out_p1),
        .mul_a(mul_a1), .mul_b(mul_b1), .mul_q(mul_q1));

`ifndef MULT8_MAC_EN
    assign out_ovf1 = 1'b0;
`endif

    mult8_seq_ctrl #(.SKIP_ZERO(0)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_a(in_a), .in_b(in_b),
`ifdef MULT8_MAC_EN
        .in_c(in_c), .out_ovf(),
`endif
        .out_valid(out_valid0), .out_ready(out_ready), .out_p(out_p0),
        .mul_a(mul_a0), .mul_b(mul_b0), .mul_q(mul_q0));

    // Drives one operation into instance sel, records the nibble pairs seen in
    // each busy cycle, and returns latency (cycles after accept) and product.
    task automatic do_op(input int sel, input logic [7:0] a, input logic [7:0] b,
                         output int lat, output logic [15:0] p, output logic ovf);
        pp_q.delete();
        @(negedge clk);
        in_a = a; in_b = b; out_ready = 1'b1;
        if (sel == 1) in_valid1 = 1'b1; else in_valid0 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0; in_valid0 = 1'b0;
        in_a = ~a; in_b = ~b;          // must not disturb the running operation
        lat = 0;
        p = 16'hxxxx;
        ovf = 1'bx;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if ((sel == 1) ? out_valid1 : out_valid0) begin
                p   = (sel == 1) ? out_p1 : out_p0;
                ovf = out_ovf1;
                break;
            end
            pp_q.push_back((sel == 1) ? {mul_a1, mul_b1} : {mul_a0, mul_b0});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid1 = 0; in_valid0 = 0; out_ready = 0;
        in_a = 0; in_b = 0; in_c = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nvec++; if (in_ready1 !== 1'b0) begin nerr++; $display("FAIL rst_in_ready got %b want 0", in_ready1); end
        nvec++; if (out_valid1 !== 1'b0) begin nerr++; $display("FAIL rst_out_valid got %b want 0", out_valid1); end
        nvec++; if (out_p1 !== 16'h0) begin nerr++; $display("FAIL rst_out_p got %h want 0000", out_p1); end
        nvec++; if ({mul_a1, mul_b1} !== 8'h00) begin nerr++; $display("FAIL rst_mul got %h want 00", {mul_a1, mul_b1}); end
        nvec++; if (out_ovf1 !== 1'b0) begin nerr++; $display("FAIL rst_ovf got %b want 0", out_ovf1); end
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        nvec++; if (in_ready1 !== 1'b1 || in_ready0 !== 1'b1) begin nerr++; $display("FAIL post_rst_in_ready got %b%b want 11", in_ready1, in_ready0); end
    endtask

    task automatic test_full();
        int lat; logic [15:0] p; logic ovf;
        do_op(1, 8'hFF, 8'hFF, lat, p, ovf);
        nvec++; if (lat !== 5) begin nerr++; $display("FAIL ff_latency got %0d want 5", lat); end
        nvec++; if (p !== 16'hFE01) begin nerr++; $display("FAIL ff_product got %h want fe01", p); end
        nvec++; if (pp_q.size() !== 4) begin nerr++; $display("FAIL ff_pp_count got %0d want 4", pp_q.size()); end
        do_op(1, 8'h12, 8'h04, lat, p, ovf);
        nvec++; if (lat !== 3) begin nerr++; $display("FAIL lo_only_latency got %0d want 3", lat); end
        nvec++; if (p !== 16'h0048) begin nerr++; $display("FAIL lo_only_product got %h want 0048", p); end
        nvec++; if (pp_q.size() !== 2 || pp_q[0] !== 8'h24 || pp_q[1] !== 8'h14) begin
            nerr++; $display("FAIL lo_only_nibbles got n=%0d want 24,14", pp_q.size()); end
    endtask

    task automatic test_skip();
        int lat; logic [15:0] p; logic ovf;
        do_op(1, 8'h5A, 8'h30, lat, p, ovf);
        nvec++; if (lat !== 3) begin nerr++; $display("FAIL skip_lo_latency got %0d want 3", lat); end
        nvec++; if (p !== 16'h10E0) begin nerr++; $display("FAIL skip_lo_product got %h want 10e0", p); end
        nvec++; if (pp_q.size() !== 2 || pp_q[0] !== 8'hA3 || pp_q[1] !== 8'h53) begin
            nerr++; $display("FAIL skip_lo_nibbles got n=%0d want a3,53", pp_q.size()); end
        do_op(1, 8'h5A, 8'h00, lat, p, ovf);
        nvec++; if (lat !== 1) begin nerr++; $display("FAIL b0_latency got %0d want 1", lat); end
        nvec++; if (p !== 16'h0000) begin nerr++; $display("FAIL b0_product got %h want 0000", p); end
    endtask

    task automatic test_noskip();
        int lat; logic [15:0] p; logic ovf;
        do_op(0, 8'h5A, 8'h00, lat, p, ovf);
        nvec++; if (lat !== 5) begin nerr++; $display("FAIL noskip_b0_latency got %0d want 5", lat); end
        nvec++; if (p !== 16'h0000) begin nerr++; $display("FAIL noskip_b0_product got %h want 0000", p); end
        do_op(0, 8'h12, 8'h34, lat, p, ovf);
        nvec++; if (lat !== 5) begin nerr++; $display("FAIL noskip_latency got %0d want 5", lat); end
        nvec++; if (p !== 16'h03A8) begin nerr++; $display("FAIL noskip_product got %h want 03a8", p); end
        nvec++; if (pp_q.size() !== 4 || pp_q[0] !== 8'h24 || pp_q[1] !== 8'h14 || pp_q[2] !== 8'h23 || pp_q[3] !== 8'h13) begin
            nerr++; $display("FAIL noskip_nibbles got n=%0d want 24,14,23,13", pp_q.size()); end
    endtask

    task automatic test_backpressure();
        int wait_n;
        @(negedge clk);
        in_a = 8'h0D; in_b = 8'h0B; out_ready = 1'b0; in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0; in_a = 8'hFF; in_b = 8'hFF;
        wait_n = 0;
        @(negedge clk);
        while (!out_valid1 && wait_n < 20) begin @(negedge clk); wait_n++; end
        nvec++; if (out_valid1 !== 1'b1) begin nerr++; $display("FAIL bp_timeout got out_valid=%b want 1", out_valid1); end
        for (int i = 0; i < 3; i++) begin
            nvec++; if (out_p1 !== 16'h008F || out_valid1 !== 1'b1 || in_ready1 !== 1'b0) begin
                nerr++; $display("FAIL bp_hold%0d got p=%h v=%b r=%b want 008f 1 0", i, out_p1, out_valid1, in_ready1); end
            @(negedge clk);
        end
        // Transfer cycle with a new request pending: it must not be taken now.
        out_ready = 1'b1; in_valid1 = 1'b1;
        nvec++; if (in_ready1 !== 1'b0) begin nerr++; $display("FAIL bp_xfer_in_ready got %b want 0", in_ready1); end
        @(negedge clk);
        in_valid1 = 1'b0;
        nvec++; if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
            nerr++; $display("FAIL bp_after got v=%b r=%b want 0 1", out_valid1, in_ready1); end
    endtask

    task automatic test_rst_mid();
        int lat; logic [15:0] p; logic ovf;
        @(negedge clk);
        in_a = 8'h5A; in_b = 8'hFF; out_ready = 1'b1; in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        repeat (3) @(negedge clk);   // now in PP2
        nvec++; if ({mul_a1, mul_b1} !== 8'hAF) begin nerr++; $display("FAIL mid_pp2_nibbles got %h want af", {mul_a1, mul_b1}); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        nvec++; if (out_valid1 !== 1'b0 || out_p1 !== 16'h0 || in_ready1 !== 1'b1) begin
            nerr++; $display("FAIL mid_rst got v=%b p=%h r=%b want 0 0000 1", out_valid1, out_p1, in_ready1); end
        wait_quiet: for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid1 !== 1'b0) begin
                nvec++; nerr++; $display("FAIL mid_rst_stray got out_valid=1 want 0");
                break;
            end
        end
        do_op(1, 8'h0D, 8'h0B, lat, p, ovf);
        nvec++; if (lat !== 3 || p !== 16'h008F) begin nerr++; $display("FAIL mid_rst_next got lat=%0d p=%h want 3 008f", lat, p); end
    endtask

`ifdef MULT8_MAC_EN
    task automatic test_mac();
        int lat; logic [15:0] p; logic ovf;
        in_c = 16'h01FF;
        do_op(1, 8'hFF, 8'hFF, lat, p, ovf);
        nvec++; if (p !== 16'h0000 || ovf !== 1'b1) begin nerr++; $display("FAIL mac_ovf got p=%h ovf=%b want 0000 1", p, ovf); end
        in_c = 16'h0010;
        do_op(1, 8'h0D, 8'h0B, lat, p, ovf);
        nvec++; if (p !== 16'h009F || ovf !== 1'b0) begin nerr++; $display("FAIL mac_add got p=%h ovf=%b want 009f 0", p, ovf); end
    endtask
`endif

    initial begin
        test_reset();
        test_full();
        test_skip();
        test_noskip();
        test_backpressure();
        test_rst_mid();
`ifdef MULT8_MAC_EN
        test_mac();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mult8_seq_ctrl.md
MULT8_SEQ_CTRL -- requirements
Module: mult8_seq_ctrl

Interface
REQ-001 Parameter: SKIP_ZERO, default 1, when 1 skips partial-product steps whose b nibble is zero.
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operand pair valid.
REQ-005 in_ready  output  1  controller can accept operands.
REQ-006 in_a  input  8  unsigned multiplicand.
REQ-007 in_b  input  8  unsigned multiplier.
REQ-008 out_valid  output  1  product valid.
REQ-009 out_ready  input  1  consumer accepts product.
REQ-010 out_p  output  16  product.
REQ-011 mul_a  output  4  nibble driven to the external combinational 4x4 array multiplier.
REQ-012 mul_b  output  4  nibble driven to the external multiplier.
REQ-013 mul_q  input  8  external multiplier result, mul_a*mul_b, same cycle.

Function
REQ-014 FSM states SHALL be IDLE, PP0, PP1, PP2, PP3, DONE.
REQ-015 Operands SHALL be captured into internal registers on in_valid & in_ready; in_ready SHALL be 1 only in IDLE.
REQ-016 Each PP state SHALL drive these nibbles: PP0 a[3:0]*b[3:0] (shift 0), PP1 a[7:4]*b[3:0] (shift 4), PP2 a[3:0]*b[7:4] (shift 4), PP3 a[7:4]*b[7:4] (shift 8).
REQ-017 Each PP state SHALL add (mul_q << shift) into a 16-bit accumulator; the final sum SHALL fit in 16 bits.
REQ-018 mul_a and mul_b SHALL be 0 in IDLE and DONE.
REQ-019 PP states SHALL be visited in order PP0..PP3; after the last visited PP state the FSM SHALL enter DONE.
REQ-020 With SKIP_ZERO=1, b[3:0]==0 SHALL skip PP0 and PP1, and b[7:4]==0 SHALL skip PP2 and PP3.
REQ-021 With SKIP_ZERO=1 and b==0, the FSM SHALL go IDLE->DONE with out_p=0.
REQ-022 With SKIP_ZERO=0, all four PP states SHALL always be visited.
REQ-023 Latency: accept at cycle N; out_valid SHALL be high at cycle N+1+k, where k is the number of visited PP states (k=4 gives N+5).
REQ-024 out_valid SHALL be 1 only in DONE, with out_p equal to the accumulator.
REQ-025 out_p SHALL hold stable while out_valid & !out_ready.
REQ-026 On out_valid & out_ready the FSM SHALL return to IDLE; in_ready SHALL rise the next cycle, with no same-cycle accept.
REQ-027 in_a/in_b changes outside the accept cycle SHALL have no effect.

Reset
REQ-028 While rst is high at a clock edge: state IDLE, accumulator 0, operand registers 0, out_valid 0, out_p 0.
REQ-029 in_ready SHALL be 0 while rst is asserted and 1 in the first cycle after deassertion.
REQ-030 rst in any non-IDLE state SHALL abandon the operation; no out_valid SHALL be produced for it.

Configuration
REQ-031 Macro MULT8_MAC_EN defined: ports in_c (input 16) and out_ovf (output 1) SHALL exist.
REQ-032 Under MULT8_MAC_EN, the accumulator SHALL load in_c on accept and be 17 bits wide.
REQ-033 Under MULT8_MAC_EN, out_p SHALL be (a*b+c) mod 2^16 and out_ovf bit 16 of the sum, cleared by reset.
REQ-034 Macro MULT8_MAC_EN undefined: in_c and out_ovf SHALL be absent and the accumulator SHALL load 0 on accept.

Verification
REQ-035 SKIP_ZERO=1, a=0xFF, b=0xFF accepted at cycle 0 -> PP0..PP3 visited, out_valid at cycle 5, out_p=0xFE01.
REQ-036 a=0x0D, b=0x0B, out_ready held 0 for 3 cycles -> out_p=0x008F stable throughout, in_ready 0 until the cycle after the transfer.
REQ-037 SKIP_ZERO=1, a=0x5A, b=0x30 -> only PP2 and PP3 visited, out_valid at cycle 3, out_p=0x10E0; b=0x00 -> out_valid at cycle 1, out_p=0.
REQ-038 SKIP_ZERO=0, b=0x00 -> all four PP states visited, out_p=0, out_valid at cycle 5.
REQ-039 rst pulsed while in PP2 -> next cycle IDLE, out_valid 0, out_p 0; a new operation completes normally.
REQ-040 MULT8_MAC_EN, a=0xFF, b=0xFF, in_c=0x01FF -> out_p=0x0000, out_ovf=1.
